// File: rtl/jtag_bs_chain.sv
// Boundary-scan register chain: input capture cells plus output data and
// output-enable cells per pad, with an update stage that drives the pads
// while EXTEST is the active instruction.
module jtag_bs_chain #(
   parameter int unsigned NUM_IN  = 2,
   parameter int unsigned NUM_OUT = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               tck_pad_i,
   input  logic               trst_pad_i,
   input  logic               capture_dr_o,
   input  logic               shift_dr_o,
   input  logic               update_dr_o,
   input  logic               extest_select_o,
   input  logic               sample_preload_select_o,
   input  logic               tdo_o,
   output logic               bs_chain_tdi_i,
   input  logic [NUM_IN-1:0]  pin_in_i,
   input  logic [NUM_OUT-1:0] core_out_i,
   input  logic [NUM_OUT-1:0] core_oe_i,
   output logic [NUM_IN-1:0]  core_in_o,
   output logic [NUM_OUT-1:0] pad_out_o,
   output logic [NUM_OUT-1:0] pad_oe_o,
   output logic [CNT_W-1:0]   shift_cnt_o
);

   localparam int unsigned L      = NUM_IN + 2 * NUM_OUT;
   localparam int unsigned OutLsb = NUM_IN;
   localparam int unsigned OeLsb  = NUM_IN + NUM_OUT;

   logic [L-1:0]       sr_q, sr_d;
   logic [L-1:0]       upd_q, upd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sel;
   logic [NUM_OUT-1:0] upd_out, upd_oe;
   logic [NUM_OUT-1:0] out_src, oe_src;

   assign sel     = extest_select_o | sample_preload_select_o;
   assign upd_out = upd_q[OutLsb +: NUM_OUT];
   assign upd_oe  = upd_q[OeLsb +: NUM_OUT];

   // EXTEST recaptures the driven pad values; SAMPLE/PRELOAD takes the core side
   assign out_src = extest_select_o ? upd_out : core_out_i;
   assign oe_src  = extest_select_o ? upd_oe  : core_oe_i;

   // Next-state: capture beats shift beats update; nothing moves without a select
   always_comb begin
      sr_d  = sr_q;
      upd_d = upd_q;
      cnt_d = cnt_q;
      if (sel) begin
         if (capture_dr_o) begin
            sr_d  = {oe_src, out_src, pin_in_i};
            cnt_d = '0;
         end else if (shift_dr_o) begin
            sr_d = {tdo_o, sr_q[L-1:1]};
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + 1'b1;
            end
         end else if (update_dr_o) begin
            upd_d = sr_q;
         end
      end
   end

   // State registers with synchronous reset that wins over every strobe
   always_ff @(posedge tck_pad_i) begin
      if (trst_pad_i) begin
         sr_q  <= '0;
         upd_q <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         upd_q <= upd_d;
         cnt_q <= cnt_d;
      end
   end

   assign bs_chain_tdi_i = sr_q[0];
   assign shift_cnt_o    = cnt_q;
   assign core_in_o      = pin_in_i;
   assign pad_out_o      = extest_select_o ? upd_out : core_out_i;
   assign pad_oe_o       = extest_select_o ? upd_oe  : core_oe_i;

endmodule
